axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = m0 always wins ties.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports m0_arid/araddr/arlen/arsize/arburst, input, 4/32/8/3/2 bits: requester 0 read address.
REQ-005 SHALL have ports m0_arvalid, input, 1 bit, and m0_arready, output, 1 bit: requester 0 AR handshake.
REQ-006 SHALL have ports m0_rid/rdata/rresp/rlast/rvalid, output, 4/32/2/1/1 bits, and m0_rready, input, 1 bit: requester 0 read data.
REQ-007 SHALL have the m1_* port set, identical to REQ-004..006: requester 1.
REQ-008 SHALL have ports s_arid/araddr/arlen/arsize/arburst/arvalid, output, 4/32/8/3/2/1 bits, and s_arready, input, 1 bit: shared AR port toward axi_interconnect controller_ar*.
REQ-009 SHALL have ports s_rid/rdata/rresp/rlast/rvalid, input, 4/32/2/1/1 bits, and s_rready, output, 1 bit: shared R port.
REQ-010 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-011 SHALL have port grant, output, 2 bits: one-hot owner, {m1,m0}; 2'b00 when IDLE.
REQ-012 SHALL have port len_err, output, 1 bit: one-cycle pulse on a burst length mismatch.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR and DATA.
REQ-014 IDLE: if any mX_arvalid is high, SHALL register the grant and go to ADDR next cycle; otherwise SHALL stay in IDLE.
REQ-015 Tie in round-robin mode: SHALL grant the requester that does not match last_grant. With FIXED_PRIO=1: SHALL grant m0.
REQ-016 ADDR: s_ar* SHALL equal the granted master's ar* combinationally; the granted mX_arready SHALL equal s_arready; all other arready outputs SHALL be 0.
REQ-017 ADDR: on s_arvalid&s_arready, SHALL load beat_cnt=0 and exp_len=arlen, then go to DATA. If arvalid drops without a handshake, SHALL remain in ADDR.
REQ-018 DATA: SHALL route s_r* to the granted mX_r* and set s_rready to the granted mX_rready; the non-granted master SHALL see rvalid/rlast/rdata/rid/rresp = 0.
REQ-019 DATA: each s_rvalid&s_rready beat SHALL increment beat_cnt (8 bits, no wrap is possible for legal bursts).
REQ-020 On a handshake beat with s_rlast=1, SHALL go to IDLE next cycle and set last_grant to the current owner.
REQ-021 SHALL pulse len_err for one cycle when rlast arrives with beat_cnt != exp_len, or when beat_cnt == exp_len on a beat without rlast.
REQ-022 A len_err condition SHALL NOT change FSM flow; only rlast ends DATA.
REQ-023 Outside ADDR: s_arvalid=0, all s_ar* fields=0, and both mX_arready=0.
REQ-024 Outside DATA: s_rready=0, and all mX_r* outputs=0.
REQ-025 Added latency SHALL be one cycle from a request seen in IDLE to s_arvalid, and zero cycles on the R path (combinational).
REQ-026 Only one burst SHALL be outstanding; a new grant SHALL be taken no earlier than the cycle after the rlast handshake.
REQ-027 A request arriving during ADDR or DATA SHALL wait; it SHALL NOT preempt the current owner.

Reset
REQ-028 While rst=1 at a clk edge, SHALL set state=IDLE, last_grant=m1 (so m0 wins the first tie), beat_cnt=0, exp_len=0, len_err=0.
REQ-029 Reset SHALL take effect mid-burst; all outputs SHALL read 0 (busy=0, grant=00) the cycle after the reset edge.

Structure
REQ-030 SHALL place the state enum, ID/ADDR/LEN width constants and the grant encoding in shared package axi_arb_pkg.
REQ-031 SHALL place tie-break and last_grant pointer logic in sub-module rr_arb2 (req[1:0], FIXED_PRIO, update strobe -> one-hot grant).

Verification
REQ-032 Single read: m0 araddr=0x0000_1000, arlen=3 -> s_arvalid 1 cycle later, 4 beats delivered to m0 only, busy low the cycle after rlast, len_err=0.
REQ-033 Simultaneous m0/m1 requests after reset, each arlen=0 -> order m0, m1; a second simultaneous pair -> m0, m1 again (alternating).
REQ-034 FIXED_PRIO=1 with both requesters continuously requesting -> every grant goes to m0; m1 is never granted.
REQ-035 m1 requests during m0's 8-beat burst (arlen=7) -> m1 is granted only after m0's rlast handshake; no beat of m0 appears on m1.
REQ-036 arlen=3 with slave rlast on beat 2 -> one len_err pulse at that beat, FSM returns to IDLE; and arlen=1 with no rlast on beat 2 -> len_err pulse, FSM stays in DATA.
REQ-037 rst asserted during beat 2 of arlen=7 -> next cycle state IDLE, all outputs 0; a subsequent m1 request is granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_arb_pkg;

  localparam int unsigned IdW    = 4;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned LenW   = 8;
  localparam int unsigned SizeW  = 3;
  localparam int unsigned BurstW = 2;
  localparam int unsigned DataW  = 32;
  localparam int unsigned RespW  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  // One-hot owner encoding, {m1, m0}
  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntM0   = 2'b01;
  localparam logic [1:0] GntM1   = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: tie-break between m0/m1 and the last-grant pointer.
module rr_arb2
  import axi_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] owner_i,
  output logic [1:0] gnt_o
);

  logic [1:0] last_q, last_d;

  // Pointer moves to the finishing owner; reset leaves m1 as last so m0 wins the first tie
  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = owner_i;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GntM1;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant selection: single requester wins outright, ties by mode
  always_comb begin
    gnt_o = GntNone;
    unique case (req_i)
      2'b01:   gnt_o = GntM0;
      2'b10:   gnt_o = GntM1;
      2'b11:   gnt_o = (FIXED_PRIO || (last_q == GntM1)) ? GntM0 : GntM1;
      default: gnt_o = GntNone;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates two AXI read requesters onto one AR/R port, one burst at a time.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IdW-1:0]    m0_arid,
  input  logic [AddrW-1:0]  m0_araddr,
  input  logic [LenW-1:0]   m0_arlen,
  input  logic [SizeW-1:0]  m0_arsize,
  input  logic [BurstW-1:0] m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [IdW-1:0]    m0_rid,
  output logic [DataW-1:0]  m0_rdata,
  output logic [RespW-1:0]  m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [IdW-1:0]    m1_arid,
  input  logic [AddrW-1:0]  m1_araddr,
  input  logic [LenW-1:0]   m1_arlen,
  input  logic [SizeW-1:0]  m1_arsize,
  input  logic [BurstW-1:0] m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [IdW-1:0]    m1_rid,
  output logic [DataW-1:0]  m1_rdata,
  output logic [RespW-1:0]  m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [IdW-1:0]    s_arid,
  output logic [AddrW-1:0]  s_araddr,
  output logic [LenW-1:0]   s_arlen,
  output logic [SizeW-1:0]  s_arsize,
  output logic [BurstW-1:0] s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [IdW-1:0]    s_rid,
  input  logic [DataW-1:0]  s_rdata,
  input  logic [RespW-1:0]  s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              len_err
);

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [LenW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LenW-1:0] exp_len_q, exp_len_d;
  logic            len_err_q, len_err_d;
  logic [1:0]      arb_gnt;
  logic            rr_update;
  logic            sel1;

  assign sel1 = owner_q[1];

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({m1_arvalid, m0_arvalid}),
    .update_i (rr_update),
    .owner_i  (owner_q),
    .gnt_o    (arb_gnt)
  );

  // State and burst-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= GntNone;
      beat_cnt_q <= '0;
      exp_len_q  <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      exp_len_q  <= exp_len_d;
      len_err_q  <= len_err_d;
    end
  end

  // Next state: grant in IDLE, AR handshake in ADDR, beat counting in DATA
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    exp_len_d  = exp_len_q;
    len_err_d  = 1'b0;
    rr_update  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_arvalid || m1_arvalid) begin
          owner_d = arb_gnt;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (s_arvalid && s_arready) begin
          beat_cnt_d = '0;
          exp_len_d  = s_arlen;
          state_d    = StData;
        end
      end
      StData: begin
        if (s_rvalid && s_rready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Early rlast or missing rlast on the final expected beat; flow is unaffected
          len_err_d  = s_rlast ? (beat_cnt_q != exp_len_q) : (beat_cnt_q == exp_len_q);
          if (s_rlast) begin
            state_d   = StIdle;
            rr_update = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: AR mux only in ADDR, R demux only in DATA, everything else zero
  always_comb begin
    busy       = (state_q != StIdle);
    grant      = (state_q != StIdle) ? owner_q : GntNone;
    len_err    = len_err_q;
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    m0_rid     = '0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rid     = '0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    if (state_q == StAddr) begin
      s_arid     = sel1 ? m1_arid    : m0_arid;
      s_araddr   = sel1 ? m1_araddr  : m0_araddr;
      s_arlen    = sel1 ? m1_arlen   : m0_arlen;
      s_arsize   = sel1 ? m1_arsize  : m0_arsize;
      s_arburst  = sel1 ? m1_arburst : m0_arburst;
      s_arvalid  = sel1 ? m1_arvalid : m0_arvalid;
      m0_arready = !sel1 && s_arready;
      m1_arready = sel1 && s_arready;
    end
    if (state_q == StData) begin
      s_rready = sel1 ? m1_rready : m0_rready;
      if (sel1) begin
        m1_rid    = s_rid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
      end else begin
        m0_rid    = s_rid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: vector table, directed corners, randomized bursts vs a grant model.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  m0_arid, m1_arid, s_arid, m0_rid, m1_rid, s_rid;
  logic [31:0] m0_araddr, m1_araddr, s_araddr, m0_rdata, m1_rdata, s_rdata;
  logic [7:0]  m0_arlen, m1_arlen, s_arlen;
  logic [2:0]  m0_arsize, m1_arsize, s_arsize;
  logic [1:0]  m0_arburst, m1_arburst, s_arburst;
  logic        m0_arvalid, m1_arvalid, s_arvalid, m0_arready, m1_arready, s_arready;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        m0_rlast, m1_rlast, s_rlast, m0_rvalid, m1_rvalid, s_rvalid;
  logic        m0_rready, m1_rready, s_rready;
  logic        busy, len_err;
  logic [1:0]  grant;

  axi_rd_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .grant(grant), .len_err(len_err)
  );

  // Fixed-priority instance: both requesters always asking, slave always ready with 1-beat bursts
  logic [3:0]  f_m0_rid, f_m1_rid, f_s_arid;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
  logic [7:0]  f_s_arlen;
  logic [2:0]  f_s_arsize;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_arburst, f_grant;
  logic        f_m0_arready, f_m1_arready, f_m0_rlast, f_m1_rlast, f_m0_rvalid, f_m1_rvalid;
  logic        f_s_arvalid, f_s_rready, f_busy, f_len_err;

  axi_rd_arbiter #(.FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .rst(rst),
    .m0_arid(4'h1), .m0_araddr(32'h100), .m0_arlen(8'd0), .m0_arsize(3'd2),
    .m0_arburst(2'd1), .m0_arvalid(1'b1), .m0_arready(f_m0_arready),
    .m0_rid(f_m0_rid), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
    .m0_rvalid(f_m0_rvalid), .m0_rready(1'b1),
    .m1_arid(4'h2), .m1_araddr(32'h200), .m1_arlen(8'd0), .m1_arsize(3'd2),
    .m1_arburst(2'd1), .m1_arvalid(1'b1), .m1_arready(f_m1_arready),
    .m1_rid(f_m1_rid), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
    .m1_rvalid(f_m1_rvalid), .m1_rready(1'b1),
    .s_arid(f_s_arid), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize),
    .s_arburst(f_s_arburst), .s_arvalid(f_s_arvalid), .s_arready(1'b1),
    .s_rid(4'h1), .s_rdata(32'hCAFE_0000), .s_rresp(2'd0), .s_rlast(1'b1),
    .s_rvalid(1'b1), .s_rready(f_s_rready),
    .busy(f_busy), .grant(f_grant), .len_err(f_len_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int f_grants = 0;
  int model_last;  // index of the master that last completed a burst

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: lone requester wins, a tie goes to whoever did not finish last
  function automatic logic [1:0] model_pick(input logic [1:0] req);
    if (req == 2'b01) return 2'b01;
    if (req == 2'b10) return 2'b10;
    return (model_last == 0) ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin
    if (rst == 1'b0) begin
      if (f_busy) begin
        check("fixed_grant", f_grant, 2'b01);
        f_grants++;
      end
      check("fixed_m1_rvalid", f_m1_rvalid, 1'b0);
      check("fixed_len_err", f_len_err, 1'b0);
    end
  end

  // One full transaction: request, AR phase, nbeats R beats (rlast on the final one)
  task automatic txn(input logic [1:0] req, input logic [1:0] late, input logic [1:0] exp_gnt,
                     input logic [7:0] len, input int nbeats, input bit stalls);
    bit own1;
    logic [31:0] exp_addr;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    logic [1:0]  exp_burst;
    logic        own_rvalid, own_rlast, oth_rvalid, own_arready, oth_arready;
    logic [31:0] own_rdata, oth_rdata;
    logic [3:0]  own_rid;
    logic [1:0]  own_rresp;
    logic        exp_err;
    int          nst;
    own1      = exp_gnt[1];
    exp_addr  = own1 ? m1_araddr : m0_araddr;
    exp_id    = own1 ? m1_arid : m0_arid;
    exp_size  = own1 ? m1_arsize : m0_arsize;
    exp_burst = own1 ? m1_arburst : m0_arburst;
    m0_arvalid = req[0];
    m1_arvalid = req[1];
    m0_arlen   = own1 ? (len ^ 8'h55) : len;
    m1_arlen   = own1 ? len : (len ^ 8'h55);
    #1;
    check("idle_s_arvalid", s_arvalid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_grant", grant, 2'b00);
    tick();
    check("addr_grant", grant, exp_gnt);
    check("addr_busy", busy, 1'b1);
    check("len_err_one_cycle", len_err, 1'b0);
    nst = stalls ? $urandom_range(2) : 0;
    s_arready = 1'b0;
    for (int i = 0; i < nst; i++) begin
      #1;
      own_arready = own1 ? m1_arready : m0_arready;
      check("ar_stall_arvalid", s_arvalid, 1'b1);
      check("ar_stall_arready", own_arready, 1'b0);
      tick();
      check("ar_stall_grant", grant, exp_gnt);
    end
    s_arready = 1'b1;
    #1;
    own_arready = own1 ? m1_arready : m0_arready;
    oth_arready = own1 ? m0_arready : m1_arready;
    check("s_arvalid", s_arvalid, 1'b1);
    check("s_araddr", s_araddr, exp_addr);
    check("s_arlen", s_arlen, len);
    check("s_arid", s_arid, exp_id);
    check("s_arsize", s_arsize, exp_size);
    check("s_arburst", s_arburst, exp_burst);
    check("own_arready", own_arready, 1'b1);
    check("oth_arready", oth_arready, 1'b0);
    tick();
    s_arready = 1'b0;
    if (own1) begin
      m1_arvalid = 1'b0;
      m0_arvalid = m0_arvalid | late[0];
    end else begin
      m0_arvalid = 1'b0;
      m1_arvalid = m1_arvalid | late[1];
    end
    for (int k = 0; k < nbeats; k++) begin
      if (stalls && ($urandom_range(3) == 0)) begin
        s_rvalid = 1'($urandom_range(1));
        s_rlast  = 1'b0;
        s_rdata  = $urandom;
        if (own1) m1_rready = !s_rvalid; else m0_rready = !s_rvalid;
        #1;
        own_rvalid = own1 ? m1_rvalid : m0_rvalid;
        oth_rvalid = own1 ? m0_rvalid : m1_rvalid;
        check("stall_s_rready", s_rready, own1 ? m1_rready : m0_rready);
        check("stall_own_rvalid", own_rvalid, s_rvalid);
        check("stall_oth_rvalid", oth_rvalid, 1'b0);
        tick();
        check("stall_len_err", len_err, 1'b0);
        check("stall_busy", busy, 1'b1);
      end
      s_rvalid = 1'b1;
      s_rlast  = (k == nbeats - 1);
      s_rdata  = $urandom;
      s_rid    = exp_id;
      s_rresp  = 2'($urandom_range(3));
      if (own1) begin
        m1_rready = 1'b1;
        m0_rready = 1'($urandom_range(1));
      end else begin
        m0_rready = 1'b1;
        m1_rready = 1'($urandom_range(1));
      end
      #1;
      own_rvalid = own1 ? m1_rvalid : m0_rvalid;
      own_rlast  = own1 ? m1_rlast : m0_rlast;
      own_rdata  = own1 ? m1_rdata : m0_rdata;
      own_rid    = own1 ? m1_rid : m0_rid;
      own_rresp  = own1 ? m1_rresp : m0_rresp;
      oth_rvalid = own1 ? m0_rvalid : m1_rvalid;
      oth_rdata  = own1 ? m0_rdata : m1_rdata;
      check("own_rvalid", own_rvalid, 1'b1);
      check("own_rdata", own_rdata, s_rdata);
      check("own_rlast", own_rlast, s_rlast);
      check("own_rid", own_rid, exp_id);
      check("own_rresp", own_rresp, s_rresp);
      check("oth_rvalid", oth_rvalid, 1'b0);
      check("oth_rdata", oth_rdata, 32'h0);
      check("s_rready", s_rready, 1'b1);
      check("data_s_arvalid", s_arvalid, 1'b0);
      check("data_grant", grant, exp_gnt);
      tick();
      exp_err = (k == nbeats - 1) ? (k != int'(len)) : (k == int'(len));
      check("len_err", len_err, exp_err);
      if (k == nbeats - 1) begin
        check("done_busy", busy, 1'b0);
        check("done_grant", grant, 2'b00);
      end else begin
        check("mid_busy", busy, 1'b1);
      end
    end
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    model_last = own1 ? 1 : 0;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] late;
    logic [7:0] len;
    int         nbeats;
    logic [1:0] gnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rq;
    logic [7:0] ln;
    int         nb;
    int         r;
    // req, late request, arlen, beats delivered, expected owner
    tbl[0] = '{2'b11, 2'b00, 8'd3, 4, 2'b01};
    tbl[1] = '{2'b11, 2'b00, 8'd0, 1, 2'b10};
    tbl[2] = '{2'b11, 2'b00, 8'd0, 1, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 8'd0, 1, 2'b10};
    tbl[4] = '{2'b01, 2'b10, 8'd7, 8, 2'b01};
    tbl[5] = '{2'b11, 2'b00, 8'd3, 3, 2'b10};
    tbl[6] = '{2'b10, 2'b00, 8'd1, 3, 2'b10};
    tbl[7] = '{2'b11, 2'b00, 8'd0, 1, 2'b01};

    rst = 1'b1;
    m0_arid = 4'h3; m0_araddr = 32'h0000_1000; m0_arlen = 8'd0; m0_arsize = 3'd2;
    m0_arburst = 2'd1; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_arid = 4'hA; m1_araddr = 32'h0000_2000; m1_arlen = 8'd0; m1_arsize = 3'd1;
    m1_arburst = 2'd2; m1_arvalid = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rid = 4'h0; s_rdata = 32'h0; s_rresp = 2'd0;
    s_rlast = 1'b0; s_rvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_len_err", len_err, 1'b0);
    check("rst_s_arvalid", s_arvalid, 1'b0);
    check("rst_s_rready", s_rready, 1'b0);
    model_last = 1;

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].req, tbl[i].late, tbl[i].gnt, tbl[i].len, tbl[i].nbeats, 1'b0);
    end

    // Reset in the middle of an 8-beat burst
    m1_arvalid = 1'b0;
    m0_arvalid = 1'b1;
    m0_arlen   = 8'd7;
    tick();
    s_arready = 1'b1;
    tick();
    s_arready  = 1'b0;
    m0_arvalid = 1'b0;
    s_rvalid   = 1'b1;
    s_rlast    = 1'b0;
    s_rdata    = 32'h1111_0000;
    m0_rready  = 1'b1;
    tick();
    s_rdata = 32'h2222_0000;
    #1;
    check("pre_rst_m0_rvalid", m0_rvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_grant", grant, 2'b00);
    check("midrst_s_rready", s_rready, 1'b0);
    check("midrst_m0_rvalid", m0_rvalid, 1'b0);
    check("midrst_m0_rdata", m0_rdata, 32'h0);
    check("midrst_len_err", len_err, 1'b0);
    check("midrst_s_arvalid", s_arvalid, 1'b0);
    s_rvalid  = 1'b0;
    m0_rready = 1'b0;
    model_last = 1;
    txn(2'b10, 2'b00, 2'b10, 8'd2, 3, 1'b0);
    txn(2'b11, 2'b00, 2'b01, 8'd0, 1, 1'b0);

    // Randomized bursts with stalls, grants predicted by the model
    for (int i = 0; i < 40; i++) begin
      rq = 2'($urandom_range(3, 1));
      ln = 8'($urandom_range(7));
      nb = int'(ln) + 1;
      r  = $urandom_range(5);
      if (r == 0) nb = int'(ln) + 2;
      else if (r == 1 && ln > 0) nb = int'(ln);
      txn(rq, 2'($urandom_range(3)), model_pick(rq), ln, nb, 1'b1);
    end

    check("fixed_instance_granted", (f_grants > 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
